// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Package : riscv_pkg
// Brief   : Opcodes, NOP encoding and fetch-state enum shared by the front end.
//           The HALT state exists only when FETCH_MISALIGN_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
package riscv_pkg;

    localparam logic [6:0]  OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]  OPC_STORE  = 7'b0100011;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    typedef enum logic [2:0] {
        FS_IDLE = 3'd0,
        FS_WAIT = 3'd1,
        FS_HOLD = 3'd2,
        FS_DROP = 3'd3
`ifdef FETCH_MISALIGN_EN
        ,
        FS_HALT = 3'd4
`endif
    } fetch_state_t;

    function automatic logic [6:0] opcode_of(input logic [31:0] instr);
        return instr[6:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module : if_id_reg
// Brief  : IF/ID pipeline register (instr, pc, valid). Flush beats load beats
//          consume; a flush replaces the instruction with a NOP.
// Rev    : 1.0  initial release
// ============================================================================
module if_id_reg
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            flush,
    input  logic            consume,
    input  logic [XLEN-1:0] d_instr,
    input  logic [XLEN-1:0] d_pc,
    output logic            valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc
);

    localparam logic [XLEN-1:0] c_nop = XLEN'(NOP_INSTR);

    logic            r_valid;
    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_instr <= c_nop;
            r_pc    <= '0;
        end else if (flush) begin
            // id_pc is left alone; only the instruction is squashed
            r_valid <= 1'b0;
            r_instr <= c_nop;
        end else if (load) begin
            r_valid <= 1'b1;
            r_instr <= d_instr;
            r_pc    <= d_pc;
        end else if (consume) begin
            r_valid <= 1'b0;
        end
    end

    assign valid = r_valid;
    assign instr = r_instr;
    assign pc    = r_pc;

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module : instr_fetch
// Brief  : RV32I fetch stage: one outstanding imem request, IF/ID register with
//          valid/ready to decode, branch redirect with wrong-path discard.
// Config : FETCH_MISALIGN_EN - misaligned redirect sets a sticky flag and halts.
// Rev    : 1.0  initial release
// ============================================================================
module instr_fetch
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic [6:0]      id_opcode,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic            fetch_misalign
);

    localparam logic [XLEN-1:0] c_pc_step = XLEN'(4);

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_imem_req;
    logic [XLEN-1:0] r_imem_addr;

    logic            w_id_valid;
    logic [XLEN-1:0] w_id_instr;
    logic [XLEN-1:0] w_id_pc;
    logic            w_load;
    logic            w_flush;
    logic            w_consume;
    logic            w_halted;
    logic            w_bad_target;
    logic [XLEN-1:0] w_target;

`ifdef FETCH_MISALIGN_EN
    logic            r_misalign;

    assign w_target       = branch_target;
    assign w_bad_target   = (branch_target[1:0] != 2'b00);
    assign w_halted       = (r_state == FS_HALT);
    assign fetch_misalign = r_misalign;
`else
    logic            w_unused_tgt_lo;

    assign w_unused_tgt_lo = ^branch_target[1:0];
    assign w_target        = {branch_target[XLEN-1:2], 2'b00};
    assign w_bad_target    = 1'b0;
    assign w_halted        = 1'b0;
    assign fetch_misalign  = 1'b0;
`endif

    always_comb begin
        w_flush   = 1'b0;
        w_load    = 1'b0;
        w_consume = 1'b0;
        if (!w_halted) begin
            if (branch_taken) begin
                w_flush = 1'b1;
            end else begin
                w_load    = (r_state == FS_WAIT) && imem_rvalid;
                w_consume = (r_state == FS_HOLD) && w_id_valid && id_ready;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= FS_IDLE;
            r_pc        <= RESET_PC;
            r_imem_req  <= 1'b0;
            r_imem_addr <= '0;
`ifdef FETCH_MISALIGN_EN
            r_misalign  <= 1'b0;
`endif
        end else begin
            r_imem_req <= 1'b0;
            if (w_halted) begin
                // HALT swallows everything, including late responses
            end else if (branch_taken && w_bad_target) begin
                r_pc <= w_target;
`ifdef FETCH_MISALIGN_EN
                r_misalign <= 1'b1;
                r_state    <= FS_HALT;
`endif
            end else if (branch_taken) begin
                r_pc <= w_target;
                // A still-outstanding response must drain before the next request
                if (!imem_rvalid && (r_state == FS_WAIT || r_state == FS_DROP)) begin
                    r_state <= FS_DROP;
                end else begin
                    r_imem_req  <= 1'b1;
                    r_imem_addr <= w_target;
                    r_state     <= FS_WAIT;
                end
            end else begin
                case (r_state)
                    FS_IDLE: begin
                        r_imem_req  <= 1'b1;
                        r_imem_addr <= r_pc;
                        r_state     <= FS_WAIT;
                    end
                    FS_WAIT: begin
                        if (imem_rvalid) begin
                            r_pc    <= r_pc + c_pc_step;
                            r_state <= FS_HOLD;
                        end
                    end
                    FS_HOLD: begin
                        if (w_consume) begin
                            r_imem_req  <= 1'b1;
                            r_imem_addr <= r_pc;
                            r_state     <= FS_WAIT;
                        end
                    end
                    FS_DROP: begin
                        if (imem_rvalid) begin
                            r_imem_req  <= 1'b1;
                            r_imem_addr <= r_pc;
                            r_state     <= FS_WAIT;
                        end
                    end
                    default: r_state <= FS_IDLE;
                endcase
            end
        end
    end

    if_id_reg #(
        .XLEN    (XLEN)
    ) u_if_id (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (w_load),
        .flush   (w_flush),
        .consume (w_consume),
        .d_instr (imem_rdata),
        .d_pc    (r_pc),
        .valid   (w_id_valid),
        .instr   (w_id_instr),
        .pc      (w_id_pc)
    );

    assign imem_req  = r_imem_req;
    assign imem_addr = r_imem_addr;
    assign id_valid  = w_id_valid;
    assign id_instr  = w_id_instr;
    assign id_pc     = w_id_pc;
    assign id_opcode = opcode_of(w_id_instr);

endmodule

`default_nettype wire
